// File: rtl/fetch_unit.sv
// Y86-64 fetch stage: reads instruction bytes over a req/ack byte port, decodes
// icode/ifun/rA/rB/valC, computes valP and hands the result downstream with valid/ready.
//   state   | meaning
//   S_OP    | request opcode byte at PC, decode icode/ifun and validate
//   S_REG   | request register-specifier byte, capture rA/rB
//   S_CONST | request the eight valC bytes, little-endian
//   S_DONE  | result presented, held until out_ready
//   S_WAIT  | idle until the next PC is loaded
//   S_STOP  | halt/fault/invalid instruction retired, idle until reset
module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] pc_in,
    input  logic        pc_load,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [7:0]  imem_rdata,
    input  logic        imem_err,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC,
    output logic [63:0] valP,
    output logic [63:0] pc_out,
    output logic [2:0]  stat
);

    typedef enum logic [2:0] {S_OP, S_REG, S_CONST, S_DONE, S_WAIT, S_STOP} state_t;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    state_t      r_state, w_state_nxt;
    logic        r_run;
    logic [63:0] r_pc, w_pc_nxt;
    logic [3:0]  r_idx, w_idx_nxt;
    logic [2:0]  r_cnt, w_cnt_nxt;
    logic [3:0]  r_icode, w_icode_nxt;
    logic [3:0]  r_ifun, w_ifun_nxt;
    logic [3:0]  r_ra, w_ra_nxt;
    logic [3:0]  r_rb, w_rb_nxt;
    logic [63:0] r_valc, w_valc_nxt;
    logic [63:0] r_valp, w_valp_nxt;
    logic [63:0] r_pc_out, w_pc_out_nxt;
    logic [2:0]  r_stat, w_stat_nxt;

    logic        w_fetching;
    logic        w_ack;
    logic        w_ins;
    logic [3:0]  w_op_icode;
    logic [3:0]  w_op_ifun;
    logic [63:0] w_valp_end;

    // r_run keeps the request low for the first cycle out of reset
    assign w_fetching = r_run && ((r_state == S_OP) || (r_state == S_REG) || (r_state == S_CONST));
    assign w_ack      = w_fetching && imem_ack;
    assign w_op_icode = imem_rdata[7:4];
    assign w_op_ifun  = imem_rdata[3:0];
    assign w_valp_end = r_pc + {60'd0, r_idx} + 64'd1;

    always_comb begin
        w_ins = 1'b0;
        case (w_op_icode)
            4'h2, 4'h7:               w_ins = (w_op_ifun > 4'h6);
            4'h6:                     w_ins = (w_op_ifun > 4'h3);
            4'hC, 4'hD, 4'hE, 4'hF:   w_ins = 1'b1;
            default:                  w_ins = (w_op_ifun != 4'h0);
        endcase
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_idx_nxt    = r_idx;
        w_cnt_nxt    = r_cnt;
        w_icode_nxt  = r_icode;
        w_ifun_nxt   = r_ifun;
        w_ra_nxt     = r_ra;
        w_rb_nxt     = r_rb;
        w_valc_nxt   = r_valc;
        w_valp_nxt   = r_valp;
        w_pc_out_nxt = r_pc_out;
        w_stat_nxt   = r_stat;
        case (r_state)
            S_OP: if (w_ack) begin
                w_idx_nxt = r_idx + 4'd1;
                if (imem_err) begin
                    w_stat_nxt  = STAT_ADR;
                    w_state_nxt = S_DONE;
                end else begin
                    w_icode_nxt = w_op_icode;
                    w_ifun_nxt  = w_op_ifun;
                    if (w_ins) begin
                        w_stat_nxt  = STAT_INS;
                        w_valp_nxt  = w_valp_end;
                        w_state_nxt = S_DONE;
                    end else begin
                        case (w_op_icode)
                            4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: w_state_nxt = S_REG;
                            4'h7, 4'h8:                               w_state_nxt = S_CONST;
                            default: begin
                                w_valp_nxt  = w_valp_end;
                                w_state_nxt = S_DONE;
                                if (w_op_icode == 4'h0) w_stat_nxt = STAT_HLT;
                            end
                        endcase
                    end
                end
            end
            S_REG: if (w_ack) begin
                w_idx_nxt = r_idx + 4'd1;
                if (imem_err) begin
                    w_stat_nxt  = STAT_ADR;
                    w_state_nxt = S_DONE;
                end else begin
                    w_ra_nxt = imem_rdata[7:4];
                    w_rb_nxt = imem_rdata[3:0];
                    if ((r_icode == 4'h3) || (r_icode == 4'h4) || (r_icode == 4'h5)) begin
                        w_state_nxt = S_CONST;
                    end else begin
                        w_valp_nxt  = w_valp_end;
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_CONST: if (w_ack) begin
                w_idx_nxt = r_idx + 4'd1;
                if (imem_err) begin
                    w_stat_nxt  = STAT_ADR;
                    w_state_nxt = S_DONE;
                end else begin
                    w_valc_nxt[{r_cnt, 3'b000} +: 8] = imem_rdata;
                    w_cnt_nxt = r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        w_valp_nxt  = w_valp_end;
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: if (out_ready) begin
                w_state_nxt = (r_stat == STAT_AOK) ? S_WAIT : S_STOP;
            end
            S_WAIT: if (pc_load) begin
                w_pc_nxt    = pc_in;
                w_idx_nxt   = 4'd0;
                w_cnt_nxt   = 3'd0;
                w_icode_nxt = 4'h0;
                w_ifun_nxt  = 4'h0;
                w_ra_nxt    = 4'hF;
                w_rb_nxt    = 4'hF;
                w_valc_nxt  = 64'd0;
                w_valp_nxt  = 64'd0;
                w_stat_nxt  = STAT_AOK;
                w_state_nxt = S_OP;
            end
            default: ;
        endcase
        if ((r_state != S_DONE) && (w_state_nxt == S_DONE)) w_pc_out_nxt = r_pc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_OP;
            r_run    <= 1'b0;
            r_pc     <= RESET_PC;
            r_idx    <= 4'd0;
            r_cnt    <= 3'd0;
            r_icode  <= 4'h0;
            r_ifun   <= 4'h0;
            r_ra     <= 4'hF;
            r_rb     <= 4'hF;
            r_valc   <= 64'd0;
            r_valp   <= 64'd0;
            r_pc_out <= 64'd0;
            r_stat   <= STAT_AOK;
        end else begin
            r_state  <= w_state_nxt;
            r_run    <= 1'b1;
            r_pc     <= w_pc_nxt;
            r_idx    <= w_idx_nxt;
            r_cnt    <= w_cnt_nxt;
            r_icode  <= w_icode_nxt;
            r_ifun   <= w_ifun_nxt;
            r_ra     <= w_ra_nxt;
            r_rb     <= w_rb_nxt;
            r_valc   <= w_valc_nxt;
            r_valp   <= w_valp_nxt;
            r_pc_out <= w_pc_out_nxt;
            r_stat   <= w_stat_nxt;
        end
    end

    assign imem_req  = w_fetching;
    assign imem_addr = r_pc + {60'd0, r_idx};
    assign out_valid = (r_state == S_DONE);
    assign icode     = r_icode;
    assign ifun      = r_ifun;
    assign rA        = r_ra;
    assign rB        = r_rb;
    assign valC      = r_valc;
    assign valP      = r_valp;
    assign pc_out    = r_pc_out;
    assign stat      = r_stat;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Fetch stage that consumes the PC produced by the next-PC/PC-update logic of the sequential Y86-64 core.
- Reads instruction bytes one at a time from byte-wide instruction memory over a req/ack handshake.
- Decodes icode, ifun, rA, rB and valC, and computes valP.
- Presents the result to decode/execute with a valid/ready handshake, then waits for the next PC.

Parameters:
- RESET_PC, 64'h0, PC fetched first after reset.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- pc_in  in  64  next PC from PC-update logic
- pc_load  in  1  pc_in is valid this cycle
- imem_req  out  1  byte read request
- imem_addr  out  64  byte address
- imem_ack  in  1  read complete this cycle
- imem_rdata  in  8  byte data, valid when imem_ack=1
- imem_err  in  1  address fault, valid when imem_ack=1
- out_valid  out  1  decoded instruction available
- out_ready  in  1  downstream accepts
- icode  out  4  instruction code
- ifun  out  4  function code
- rA  out  4  register A (4'hF if absent)
- rB  out  4  register B (4'hF if absent)
- valC  out  64  constant, little-endian assembled (0 if absent)
- valP  out  64  PC + instruction length
- pc_out  out  64  PC of this instruction
- stat  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS

Behaviour:
- Reset (async, rst_n=0):
  - PC=RESET_PC, state=OP; imem_req=0, out_valid=0.
  - icode=ifun=0, rA=rB=4'hF, valC=0, valP=0, pc_out=0, stat=1.
  - Fetch of RESET_PC starts on the first clock after rst_n rises.
- States: OP, REG, CONST, DONE, WAIT, STOP.
- Memory handshake:
  - In OP/REG/CONST, imem_req=1 and imem_addr=PC+byte_index, held stable until imem_ack.
  - Same-cycle ack is legal. rdata/err are sampled on the ack edge.
  - After an ack the next byte may be requested back-to-back (req stays 1, addr advances).
  - imem_req=0 in DONE/WAIT/STOP.
- Lengths by icode:
  - 0 halt, 1 nop, 9 ret: 1 byte.
  - 2 cmovXX, 6 OPq, A pushq, B popq: 2 bytes (OP→REG).
  - 3 irmovq, 4 rmmovq, 5 mrmovq: 10 bytes (OP→REG→CONST×8).
  - 7 jXX, 8 call: 9 bytes (OP→CONST×8).
- CONST uses a 3-bit counter 0..7. Byte k loads valC[8k+7:8k].
- Register byte: rA=rdata[7:4], rB=rdata[3:0].
- valP = PC + length, 64-bit, wraps modulo 2^64. Address PC+byte_index also wraps.
- Validity checks on the OP byte:
  - icode > B → stat=INS, no further bytes.
  - ifun checks: ifun>6 for icode 2/7 → INS; ifun>3 for icode 6 → INS; ifun≠0 for any other icode → INS.
  - icode 0 → stat=HLT.
  - On INS: valP=PC+1; valC, rA, rB at defaults.
- imem_err on any ack → stat=ADR; fetch ends immediately; fields captured so far are kept, others default.
- DONE:
  - out_valid=1; all outputs held stable until out_valid&&out_ready.
  - On acceptance: stat=AOK → WAIT; stat≠AOK → STOP.
- WAIT: on pc_load, PC=pc_in, field registers are cleared, and the next state is OP. pc_load in any other state is ignored.
- STOP: remains until reset; out_valid=0.
- Latency: with zero-wait memory, out_valid rises N cycles after OP is entered (N = length, or fewer on error/INS).
- Reset mid-fetch aborts immediately; no partial output.

Test Plan:
- Reset, RESET_PC=0, memory {10 (nop)}, zero-wait, out_ready=1 → out_valid cycle 1, icode=1, valP=1, stat=1, pc_out=0; then WAIT with imem_req=0.
- pc_load pc_in=0x20, memory at 0x20 = 30 F3 08 07 06 05 04 03 02 01 (irmovq) → 10 requests at 0x20..0x29, icode=3, rA=F, rB=3, valC=0x0102030405060708, valP=0x2A.
- call 80 + 8 bytes with ack delayed 3 cycles per byte and out_ready low for 4 cycles → imem_addr stable during each wait, outputs stable until accepted, valP=PC+9.
- OP byte 0xC0 → stat=4, out_valid after 1 byte, valP=PC+1, STOP after acceptance, later pc_load ignored.
- imem_err on byte 3 of mrmovq → stat=3, fetch ends, rA/rB from byte 2, valC=0; STOP.
- rst_n low during CONST byte 5 → req=0 and out_valid=0 immediately; restart from RESET_PC after release. Also halt 00 → stat=2, STOP.
